q_avg_win: RTL and testbench

Block-average stage for the reactive-power result. It consumes the single-precision Q sample and start pulse produced by the reactive-power calculation stage, and accumulates 2^LOG2N consecutive samples with one pipelined Adder_nodsp. It then scales the sum by 2^-LOG2N through exponent arithmetic and presents the window mean, with a one-cycle done_sig, to the wind-turbine control logic.

---
 rtl/q_avg_win.sv | 153 +++++++++++++++
 tb/tb_q_avg_win.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/q_avg_win.sv
// q_avg_win: averages 2^LOG2N single-precision Q samples through a pipelined float adder.
// Define Q_AVG_NAN_GUARD_EN to replace Inf/NaN samples with +0.0 and flag them on ovr.
module q_avg_win #(
  parameter int LOG2N = 4,
  parameter int ADD_LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sta,
  input  logic [31:0] Q,
  output logic [31:0] Q_avg,
  output logic        done_sig,
  output logic        busy,
  output logic        ovr
);
  localparam int LW = $clog2(ADD_LAT + 1);
  typedef enum logic [1:0] {IDLE, ADD, SCALE} state_t;
  state_t state_q, state_d;
  logic [31:0] acc_q, acc_d, pend_q, pend_d, a_q, a_d, b_q, b_d, q_avg_q, q_avg_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic pend_v_q, pend_v_d, done_q, done_d, ovr_q, ovr_d, drop;
  logic [ADD_LAT-2:0][31:0] pipe_q, pipe_d;
  logic [31:0] smp, scaled;
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [8:0] ea, eb, d, e;
    logic [26:0] ma, mb, sh;
    logic [27:0] s;
    logic [24:0] r;
    if (x[30:23] == 8'hff || y[30:23] == 8'hff)
      return (x[30:23] == 8'hff && y[30:23] == 8'hff && x != y) ? 32'h7fc00000 :
             (x[30:23] == 8'hff ? x : y);
    {a, b} = (x[30:0] >= y[30:0]) ? {x, y} : {y, x};
    ea = (a[30:23] == 8'd0) ? 9'd1 : {1'b0, a[30:23]};
    eb = (b[30:23] == 8'd0) ? 9'd1 : {1'b0, b[30:23]};
    ma = {a[30:23] != 8'd0, a[22:0], 3'b0};
    mb = {b[30:23] != 8'd0, b[22:0], 3'b0};
    d = ea - eb;
    if (d >= 9'd27) sh = {26'd0, mb != 27'd0};
    else begin
      sh = mb >> d;
      sh[0] = sh[0] | ((mb & ((27'd1 << d) - 27'd1)) != 27'd0);
    end
    s = (a[31] == b[31]) ? {1'b0, ma} + {1'b0, sh} : {1'b0, ma} - {1'b0, sh};
    if (s == 28'd0) return {a[31] & b[31], 31'b0};
    e = ea;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 9'd1;
    end else
      for (int i = 0; i < 27; i++)
        if (!s[26] && e > 9'd1) begin
          s = s << 1;
          e = e - 9'd1;
        end
    r = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 9'd1;
    end
    return (e >= 9'd255) ? {a[31], 8'hff, 23'b0} : {a[31], r[23] ? e[7:0] : 8'd0, r[22:0]};
  endfunction
  assign smp = pend_v_q ? pend_q : Q;
`ifdef Q_AVG_NAN_GUARD_EN
  assign drop = smp[30:23] == 8'hff;
`else
  assign drop = 1'b0;
`endif
  // Dividing by 2^LOG2N only moves the exponent; tiny sums flush to signed zero.
  assign scaled = (acc_q[30:23] == 8'hff) ? acc_q :
                  (acc_q[30:23] <= 8'(LOG2N)) ? {acc_q[31], 31'b0} :
                  {acc_q[31], acc_q[30:23] - 8'(LOG2N), acc_q[22:0]};
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    a_d = a_q;
    b_d = b_q;
    q_avg_d = q_avg_q;
    done_d = 1'b0;
    ovr_d = ovr_q;
    pipe_d[0] = fadd(a_q, b_q);
    for (int i = 1; i < ADD_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
    if (state_q == IDLE) begin
      if (pend_v_q || sta) begin
        a_d = (cnt_q == '0) ? 32'h0 : acc_q;
        b_d = drop ? 32'h0 : smp;
        ovr_d = ovr_q | drop;
        pend_d = sta ? Q : pend_q;
        pend_v_d = pend_v_q & sta;
        lat_d = '0;
        state_d = ADD;
      end
    end else begin
      if (sta) begin
        ovr_d = ovr_q | pend_v_q;
        pend_d = pend_v_q ? pend_q : Q;
        pend_v_d = 1'b1;
      end
      if (state_q == ADD) begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LW'(ADD_LAT - 1)) begin
          acc_d = pipe_q[ADD_LAT-2];
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == '1) ? SCALE : IDLE;
        end
      end else begin
        q_avg_d = scaled;
        done_d = 1'b1;
        cnt_d = '0;
        acc_d = 32'h0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= 32'h0;
      cnt_q <= '0;
      lat_q <= '0;
      pend_q <= 32'h0;
      pend_v_q <= 1'b0;
      a_q <= 32'h0;
      b_q <= 32'h0;
      q_avg_q <= 32'h0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      a_q <= a_d;
      b_q <= b_d;
      q_avg_q <= q_avg_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
      pipe_q <= pipe_d;
    end
  end
  assign Q_avg = q_avg_q;
  assign done_sig = done_q;
  assign busy = state_q != IDLE;
  assign ovr = ovr_q;
endmodule

// File: tb/tb_q_avg_win.sv
// tb_q_avg_win: randomized and directed windows against an exact integer-mean reference.
module tb_q_avg_win;
  localparam int LOG2N = 4, ADD_LAT = 7, N = 1 << LOG2N;
  logic clk = 1'b0, rst = 1'b1, sta = 1'b0;
  logic [31:0] Q = 32'h0, Q_avg;
  logic done_sig, busy, ovr;
  int errs = 0, checks = 0, dn = 0;
  logic [31:0] win [N];
  q_avg_win #(.LOG2N(LOG2N), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .sta(sta), .Q(Q),
    .Q_avg(Q_avg), .done_sig(done_sig), .busy(busy), .ovr(ovr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done_sig) dn++;
  // Exact float encoding of num / 2^sh; valid while |num| < 2^24.
  function automatic logic [31:0] to_single(input int num, input int sh);
    int mag, p;
    if (num == 0) return 32'h0;
    mag = (num < 0) ? -num : num;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    return {num < 0, 8'(127 + p - sh), 23'(mag << (23 - p))};
  endfunction
  task automatic send(input logic [31:0] v, input int gap);
    sta = 1'b1;
    Q = v;
    @(posedge clk);
    #1 sta = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_sig && k < 40);
  endtask
  task automatic play(input int gap, output int k, output logic [31:0] val);
    for (int i = 0; i < N - 1; i++) send(win[i], gap);
    send(win[N-1], 1);
    wait_done(k);
    val = Q_avg;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks += 4;
    if (Q_avg !== 32'h0) begin errs++; $display("FAIL reset_q_avg got %h want 00000000", Q_avg); end
    if (done_sig !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done_sig); end
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    if (ovr !== 1'b0) begin errs++; $display("FAIL reset_ovr got %b want 0", ovr); end
  endtask
  task automatic test_const;
    int k, d0;
    logic [31:0] v;
    for (int i = 0; i < N; i++) win[i] = 32'h40800000;
    d0 = dn;
    play(20, k, v);
    repeat (15) @(negedge clk);
    checks += 4;
    if (k !== ADD_LAT + 2) begin errs++; $display("FAIL const_latency got %0d want %0d", k, ADD_LAT + 2); end
    if (v !== 32'h40800000) begin errs++; $display("FAIL const_value got %h want 40800000", v); end
    if (dn - d0 !== 1) begin errs++; $display("FAIL const_done_count got %0d want 1", dn - d0); end
    if (busy !== 1'b0) begin errs++; $display("FAIL const_busy got %b want 0", busy); end
  endtask
  task automatic test_alternating;
    int k;
    logic [31:0] v;
    for (int i = 0; i < N; i++) win[i] = i[0] ? 32'hC0400000 : 32'h40400000;
    play(ADD_LAT + 2, k, v);
    checks++;
    if (v !== 32'h0) begin errs++; $display("FAIL alt_zero got %h want 00000000", v); end
    for (int i = 0; i < N; i++) win[i] = 32'h40000000;
    play(ADD_LAT + 3, k, v);
    checks++;
    if (v !== 32'h40000000) begin errs++; $display("FAIL alt_second got %h want 40000000", v); end
  endtask
  task automatic test_burst;
    int k;
    do_reset();
    send(32'h41800000, 1);
    send(32'h42000000, 1);
    send(32'h42800000, 20);
    checks++;
    if (ovr !== 1'b1) begin errs++; $display("FAIL burst_ovr got %b want 1", ovr); end
    for (int i = 0; i < N - 3; i++) send(32'h0, 10);
    send(32'h0, 1);
    wait_done(k);
    checks += 2;
    if (Q_avg !== 32'h40400000) begin errs++; $display("FAIL burst_sum got %h want 40400000", Q_avg); end
    if (ovr !== 1'b1) begin errs++; $display("FAIL burst_ovr_sticky got %b want 1", ovr); end
  endtask
  task automatic test_mid_rst;
    int k, d0;
    logic [31:0] v;
    for (int i = 0; i < 9; i++) send(32'h40A00000, 10);
    send(32'h40A00000, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    d0 = dn;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (ovr !== 1'b0) begin errs++; $display("FAIL midrst_ovr got %b want 0", ovr); end
    if (Q_avg !== 32'h0) begin errs++; $display("FAIL midrst_q_avg got %h want 00000000", Q_avg); end
    repeat (30) @(negedge clk);
    checks++;
    if (dn !== d0) begin errs++; $display("FAIL midrst_no_done got %0d want %0d", dn, d0); end
    for (int i = 0; i < N; i++) win[i] = 32'h3F800000;
    play(10, k, v);
    checks += 2;
    if (v !== 32'h3F800000) begin errs++; $display("FAIL midrst_next got %h want 3f800000", v); end
    if (k !== ADD_LAT + 2) begin errs++; $display("FAIL midrst_latency got %0d want %0d", k, ADD_LAT + 2); end
  endtask
  task automatic test_random;
    int k, sum, x;
    logic [31:0] exp_v;
    do_reset();
    for (int w = 0; w < 4; w++) begin
      sum = 0;
      for (int i = 0; i < N; i++) begin
        x = int'($urandom_range(200)) - 100;
        win[i] = to_single(x, 0);
        sum += x;
      end
      exp_v = to_single(sum, LOG2N);
      for (int i = 0; i < N - 1; i++) send(win[i], int'($urandom_range(14, ADD_LAT + 2)));
      send(win[N-1], 1);
      wait_done(k);
      checks += 2;
      if (Q_avg !== exp_v) begin errs++; $display("FAIL random_w%0d got %h want %h", w, Q_avg, exp_v); end
      if (ovr !== 1'b0) begin errs++; $display("FAIL random_ovr_w%0d got %b want 0", w, ovr); end
    end
  endtask
  task automatic test_back_to_back;
    int k, sum, x;
    logic [31:0] v, exp_v;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      x = int'($urandom_range(1000)) - 500;
      win[i] = to_single(x, 0);
      sum += x;
    end
    exp_v = to_single(sum, LOG2N);
    play(ADD_LAT + 1, k, v);
    checks += 3;
    if (v !== exp_v) begin errs++; $display("FAIL b2b_value got %h want %h", v, exp_v); end
    if (ovr !== 1'b0) begin errs++; $display("FAIL b2b_ovr got %b want 0", ovr); end
    if (k !== ADD_LAT + 2) begin errs++; $display("FAIL b2b_latency got %0d want %0d", k, ADD_LAT + 2); end
  endtask
  task automatic test_nan;
    int k;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < N; i++) win[i] = 32'h41000000;
    win[5] = 32'h7FC00000;
    play(10, k, v);
    checks += 2;
`ifdef Q_AVG_NAN_GUARD_EN
    if (v !== 32'h40F00000) begin errs++; $display("FAIL nan_guard_value got %h want 40f00000", v); end
    if (ovr !== 1'b1) begin errs++; $display("FAIL nan_guard_ovr got %b want 1", ovr); end
`else
    if (v[30:23] !== 8'hff) begin errs++; $display("FAIL nan_exp got %h want ff", v[30:23]); end
    if (ovr !== 1'b0) begin errs++; $display("FAIL nan_ovr got %b want 0", ovr); end
`endif
  endtask
  initial begin
    test_reset();
    test_const();
    test_alternating();
    test_burst();
    test_mid_rst();
    test_random();
    test_back_to_back();
    test_nan();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
